// File: rtl/aes_stream_pkg.sv
// ============================================================================
// Module      : aes_stream_pkg
// Description : Shared constants, types and helpers for the AES stream
//               stacker/unstacker pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } stacker_state_t;

    // Ones over the first n word slots, counted from the MSW down.
    function automatic logic [BLOCK_W-1:0] slot_mask(input logic [2:0] n);
        logic [BLOCK_W-1:0] m;
        m = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            if (i < int'(n)) begin
                m[BLOCK_W-1-WORD_W*i -: WORD_W] = '1;
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_swap32.sv
// ============================================================================
// Module      : byte_swap32
// Description : Parameter-selected 32-bit byte reversal (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_swap32 #(
    parameter bit EN = 1'b0
) (
    input  logic [31:0] d_i,
    output logic [31:0] d_o
);

    generate
        if (EN) begin : g_swap
            assign d_o = {d_i[7:0], d_i[15:8], d_i[23:16], d_i[31:24]};
        end else begin : g_pass
            assign d_o = d_i;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/word_stacker.sv
// ============================================================================
// Module      : word_stacker
// Description : Packs four 32-bit stream words (MSW first) into a 128-bit
//               block, with zero-padding flush for partial tail blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_stacker
    import aes_stream_pkg::*;
#(
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 enable_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WORD_W-1:0]    word_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [BLOCK_W-1:0]   word_o,
    output logic [1:0]           cnt_o
);

    stacker_state_t       state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BLOCK_W-1:0]   stack_q, stack_d;
    logic [WORD_W-1:0]    word_sw;
    logic [BLOCK_W-1:0]   stack_wr;
    logic [2:0]           filled;
    logic                 in_fill;
    logic                 accept;

    byte_swap32 #(
        .EN (SWAP_BYTES)
    ) u_swap (
        .d_i (word_i),
        .d_o (word_sw)
    );

    assign in_fill = (state_q == FILL);
    // Gated by rst_ni so nothing is accepted while reset is held.
    assign ready_o = rst_ni & enable_i & in_fill;
    assign valid_o = enable_i & ~in_fill;
    assign word_o  = in_fill ? '0 : stack_q;
    assign cnt_o   = cnt_q;
    assign accept  = valid_i & ready_o;
    assign filled  = {1'b0, cnt_q} + {2'b00, accept};

    always_comb begin
        stack_wr = stack_q;
        if (accept) begin
            case (cnt_q)
                2'd0:    stack_wr[127:96] = word_sw;
                2'd1:    stack_wr[95:64]  = word_sw;
                2'd2:    stack_wr[63:32]  = word_sw;
                default: stack_wr[31:0]   = word_sw;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stack_d = stack_q;
        if (enable_i) begin
            case (state_q)
                FILL: begin
                    if (accept && cnt_q == 2'd3) begin
                        state_d = FULL;
                        cnt_d   = 2'd0;
                        stack_d = stack_wr;
                    end else if (flush_i && filled != 3'd0) begin
                        state_d = FULL;
                        cnt_d   = 2'd0;
                        stack_d = stack_wr & slot_mask(filled);
                    end else if (accept) begin
                        cnt_d   = cnt_q + 2'd1;
                        stack_d = stack_wr;
                    end
                end
                FULL: begin
                    if (ready_i) begin
                        state_d = FILL;
                        stack_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = 2'd0;
                    stack_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= 2'd0;
            stack_q <= '0;
        end else if (clr_i) begin
            state_q <= FILL;
            cnt_q   <= 2'd0;
            stack_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_word_stacker.sv
// ============================================================================
// Module      : tb_word_stacker
// Description : Self-checking bench for word_stacker (plain and byte-swapped).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_stacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr, en, vld_in, flush, rdy_in;
    logic [31:0]  word_in;

    logic         rdy0, vld0, rdy1, vld1;
    logic [127:0] wo0, wo1;
    logic [1:0]   cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    // Reference model: held raw words and the presented block per variant.
    bit           m_full;
    logic [31:0]  m_held[$];
    logic [127:0] m_blk0, m_blk1;

    always #5 clk = ~clk;

    word_stacker #(.SWAP_BYTES(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
        .valid_i(vld_in), .ready_o(rdy0), .word_i(word_in), .flush_i(flush),
        .valid_o(vld0), .ready_i(rdy_in), .word_o(wo0), .cnt_o(cnt0)
    );

    word_stacker #(.SWAP_BYTES(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
        .valid_i(vld_in), .ready_o(rdy1), .word_i(word_in), .flush_i(flush),
        .valid_o(vld1), .ready_i(rdy_in), .word_o(wo1), .cnt_o(cnt1)
    );

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_full = 1'b0;
        m_held.delete();
        m_blk0 = '0;
        m_blk1 = '0;
    endtask

    task automatic model_present();
        m_blk0 = '0;
        m_blk1 = '0;
        foreach (m_held[i]) begin
            m_blk0[127-32*i -: 32] = m_held[i];
            m_blk1[127-32*i -: 32] = bswap(m_held[i]);
        end
        m_held.delete();
        m_full = 1'b1;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic         e_rdy, e_vld;
        logic [127:0] e_w0, e_w1;
        logic [1:0]   e_cnt;
        @(negedge clk);
        if (!rst_n) model_clear();
        e_rdy = rst_n & en & !m_full;
        e_vld = en & m_full;
        e_w0  = m_full ? m_blk0 : '0;
        e_w1  = m_full ? m_blk1 : '0;
        e_cnt = 2'(m_held.size());
        chk("ready0", 128'(rdy0), 128'(e_rdy));
        chk("valid0", 128'(vld0), 128'(e_vld));
        chk("word0",  wo0,        e_w0);
        chk("cnt0",   128'(cnt0), 128'(e_cnt));
        chk("ready1", 128'(rdy1), 128'(e_rdy));
        chk("valid1", 128'(vld1), 128'(e_vld));
        chk("word1",  wo1,        e_w1);
        chk("cnt1",   128'(cnt1), 128'(e_cnt));
        if (!rst_n || clr) begin
            model_clear();
        end else if (en) begin
            if (!m_full) begin
                if (vld_in) m_held.push_back(word_in);
                if (m_held.size() == 4 || (flush && m_held.size() > 0)) model_present();
            end else if (rdy_in) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w);
        vld_in  = 1'b1;
        word_in = w;
        cycle();
        vld_in  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b1; vld_in = 1'b0;
        flush = 1'b0; rdy_in = 1'b1; word_in = '0;
        model_clear();

        // Reset state with enable high: ready must still be low.
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", 128'(rdy0), 128'd1);

        // Basic block, ready_i high.
        feed(32'h00010203); feed(32'h04050607); feed(32'h08090A0B); feed(32'h0C0D0E0F);
        chk("plan1_valid", 128'(vld0), 128'd1);
        chk("plan1_word",  wo0, 128'h000102030405060708090A0B0C0D0E0F);
        cycle();
        chk("plan1_back_to_fill", 128'(rdy0), 128'd1);

        // Backpressure for 10 cycles in FULL, valid_i asserted throughout.
        rdy_in = 1'b0;
        feed(32'hDEAD0001); feed(32'hDEAD0002); feed(32'hDEAD0003); feed(32'hDEAD0004);
        vld_in = 1'b1; word_in = 32'h55555555;
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_word", wo0, 128'hDEAD0001DEAD0002DEAD0003DEAD0004);
        vld_in = 1'b0; rdy_in = 1'b1;
        cycle();
        chk("bp_released", 128'(vld0), 128'd0);

        // Flush after two words, then flush with nothing held.
        feed(32'hAAAAAAAA); feed(32'hBBBBBBBB);
        flush = 1'b1; rdy_in = 1'b0;
        cycle();
        flush = 1'b0;
        chk("flush2_word", wo0, 128'hAAAAAAAABBBBBBBB0000000000000000);
        rdy_in = 1'b1;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_empty_novalid", 128'(vld0), 128'd0);

        // Flush coincident with the third accept.
        feed(32'h11111111); feed(32'h22222222);
        flush = 1'b1; rdy_in = 1'b0;
        feed(32'hCCCCCCCC);
        flush = 1'b0;
        chk("flush3_word", wo0, 128'h1111111122222222CCCCCCCC00000000);
        rdy_in = 1'b1;
        cycle();

        // Byte-swapped variant.
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) feed(32'h00112233);
        chk("swap_word", wo1, {4{32'h33221100}});
        rdy_in = 1'b1;
        cycle();

        // Enable low holds state; clr then wipes it.
        feed(32'h01020304); feed(32'h05060708);
        en = 1'b0; vld_in = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("en_low_cnt", 128'(cnt0), 128'd2);
        chk("en_low_ready", 128'(rdy0), 128'd0);
        vld_in = 1'b0; en = 1'b1; clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_cnt", 128'(cnt0), 128'd0);
        rdy_in = 1'b0;
        feed(32'hA0A0A0A0); feed(32'hB1B1B1B1); feed(32'hC2C2C2C2); feed(32'hD3D3D3D3);
        chk("clr_clean_block", wo0, 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3);
        rdy_in = 1'b1;
        cycle();

        // Randomized traffic against the model, with rare clears and async resets.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            vld_in  = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 9) == 0);
            rdy_in  = ($urandom_range(0, 9) < 6);
            clr     = ($urandom_range(0, 49) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            word_in = $urandom;
            cycle();
        end
        rst_n = 1'b1; clr = 1'b0; vld_in = 1'b0; flush = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
